// File: rtl/ddr_phy_pkg.sv
// Shared definitions for the DDR CA lane controller slice.
//   dl_state_e : delay-line step sequencer states
//   TAP_W_DEF  : default tap counter width
//   lane_lsb() : LSB position of a lane inside a lane-major flat bus
package ddr_phy_pkg;

   typedef enum logic [2:0] {
      DL_IDLE   = 3'd0,
      DL_LOAD   = 3'd1,
      DL_MOVE   = 3'd2,
      DL_SETTLE = 3'd3,
      DL_DONE   = 3'd4
   } dl_state_e;

   localparam int TAP_W_DEF = 8;

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/ddr_dl_step_seq.sv
// Delay-line step sequencer for a group of output lanes. Accepts one
// adjust request at a time, then either reloads the target lane or issues
// single-tap MOVE pulses separated by a settle gap, tracking the tap value
// of every lane and stopping at the tap range limits or on out-of-range.
//
// Ports
//   clk_sys, rst_b       clock, async active-low reset
//   adj_req..adj_steps   request handshake fields (held until adj_ack)
//   oor_chk              per-lane out-of-range flag used by the bounds check
//   adj_ack/adj_err      one-cycle completion pulse and truncation flag
//   adj_busy             sequencer not idle
//   dl_move/dl_load      one-hot registered pulses to the IOD
//   dl_dir               per-lane direction, held for the whole request
//   tap_val              lane-major tracked tap values
//
// state     | meaning
// ----------+------------------------------------------------------------
// DL_IDLE   | waiting for adj_req; latches the request fields
// DL_LOAD   | issues the LOAD pulse and resets the tracked tap
// DL_MOVE   | bounds check; one MOVE pulse or stop with error
// DL_SETTLE | down-counts the settle gap after LOAD/MOVE
// DL_DONE   | one-cycle adj_ack with adj_err
module ddr_dl_step_seq
   import ddr_phy_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int TAP_W      = TAP_W_DEF,
   parameter int TAP_INIT   = 1,
   parameter int SETTLE_CYC = 4,
   parameter int CH_W       = 1
) (
   input  logic                    clk_sys,
   input  logic                    rst_b,
   input  logic                    adj_req,
   input  logic [CH_W-1:0]         adj_ch,
   input  logic                    adj_load,
   input  logic                    adj_dir,
   input  logic [TAP_W-1:0]        adj_steps,
   input  logic [NUM_CH-1:0]       oor_chk,
   output logic                    adj_ack,
   output logic                    adj_err,
   output logic                    adj_busy,
   output logic [NUM_CH-1:0]       dl_move,
   output logic [NUM_CH-1:0]       dl_dir,
   output logic [NUM_CH-1:0]       dl_load,
   output logic [NUM_CH*TAP_W-1:0] tap_val
);

   localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SC_W-1:0]  SETTLE_LD = SC_W'(SETTLE_CYC - 1);
   localparam logic [TAP_W-1:0] TAP_RST   = TAP_W'(TAP_INIT);
   localparam logic [TAP_W-1:0] TAP_MAX   = '1;
   localparam logic [TAP_W-1:0] TAP_ONE   = TAP_W'(1);
   localparam logic [CH_W:0]    NUM_CH_L  = (CH_W+1)'(NUM_CH);

   dl_state_e          state_q, state_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic               dir_q, dir_d;
   logic [TAP_W-1:0]   steps_q, steps_d;
   logic               err_q, err_d;
   logic [SC_W-1:0]    settle_q, settle_d;
   logic [NUM_CH-1:0]  move_q, move_d;
   logic [NUM_CH-1:0]  load_q, load_d;
   logic [TAP_W-1:0]   tap_q [NUM_CH];
   logic [TAP_W-1:0]   tap_d [NUM_CH];

   logic [TAP_W-1:0]   tap_cur;
   logic               oor_cur;
   logic               stop;
   logic               ch_in_ok;

   // Lane mux for the latched target lane; an invalid lane selects nothing.
   always_comb begin
      tap_cur = '0;
      oor_cur = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_q == CH_W'(c)) begin
            tap_cur = tap_q[c];
            oor_cur = oor_chk[c];
         end
      end
   end

   assign stop     = oor_cur | (dir_q ? (tap_cur == TAP_MAX) : (tap_cur == '0));
   assign ch_in_ok = ({1'b0, adj_ch} < NUM_CH_L);

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      dir_d    = dir_q;
      steps_d  = steps_q;
      err_d    = err_q;
      settle_d = settle_q;
      move_d   = '0;
      load_d   = '0;
      tap_d    = tap_q;

      unique case (state_q)
         DL_IDLE: begin
            if (adj_req) begin
               ch_d    = adj_ch;
               dir_d   = adj_load ? 1'b0 : adj_dir;
               steps_d = adj_load ? '0 : adj_steps;
               err_d   = 1'b0;
               if (!ch_in_ok) begin
                  err_d   = 1'b1;
                  state_d = DL_DONE;
               end else if (adj_load) begin
                  state_d = DL_LOAD;
               end else if (adj_steps != '0) begin
                  state_d = DL_MOVE;
               end else begin
                  state_d = DL_DONE;
               end
            end
         end
         DL_LOAD: begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (ch_q == CH_W'(c)) begin
                  load_d[c] = 1'b1;
                  tap_d[c]  = TAP_RST;
               end
            end
            settle_d = SETTLE_LD;
            state_d  = DL_SETTLE;
         end
         DL_MOVE: begin
            if (stop) begin
               err_d   = 1'b1;
               state_d = DL_DONE;
            end else begin
               for (int c = 0; c < NUM_CH; c++) begin
                  if (ch_q == CH_W'(c)) begin
                     move_d[c] = 1'b1;
                     tap_d[c]  = dir_q ? (tap_q[c] + TAP_ONE) : (tap_q[c] - TAP_ONE);
                  end
               end
               steps_d  = steps_q - TAP_ONE;
               settle_d = SETTLE_LD;
               state_d  = DL_SETTLE;
            end
         end
         DL_SETTLE: begin
            if (settle_q == '0) begin
               state_d = (steps_q != '0) ? DL_MOVE : DL_DONE;
            end else begin
               settle_d = settle_q - SC_W'(1);
            end
         end
         DL_DONE: begin
            state_d = DL_IDLE;
         end
         default: begin
            state_d = DL_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         state_q  <= DL_IDLE;
         ch_q     <= '0;
         dir_q    <= 1'b0;
         steps_q  <= '0;
         err_q    <= 1'b0;
         settle_q <= '0;
         move_q   <= '0;
         load_q   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            tap_q[c] <= TAP_RST;
         end
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         dir_q    <= dir_d;
         steps_q  <= steps_d;
         err_q    <= err_d;
         settle_q <= settle_d;
         move_q   <= move_d;
         load_q   <= load_d;
         for (int c = 0; c < NUM_CH; c++) begin
            tap_q[c] <= tap_d[c];
         end
      end
   end

   assign adj_ack  = (state_q == DL_DONE);
   assign adj_err  = adj_ack & err_q;
   assign adj_busy = (state_q != DL_IDLE);
   assign dl_move  = move_q;
   assign dl_load  = load_q;

   // Pulses are registered, so the direction latched at acceptance is
   // already stable on the cycle before each MOVE pulse reaches the IOD.
   always_comb begin
      dl_dir  = '0;
      tap_val = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         dl_dir[c] = adj_busy & (ch_q == CH_W'(c)) & dir_q;
         tap_val[lane_lsb(c, TAP_W) +: TAP_W] = tap_q[c];
      end
   end

endmodule

// File: rtl/ddr_ca_lane_ctrl.sv
// Fabric-side controller for a group of DDR4 address/command output lanes
// on TX-only IOD slices. Registers the serialised TX and OE words with an
// OE postamble and idle drive level, and runs the delay-line training
// sequencer (ddr_dl_step_seq) that issues LOAD/MOVE pulses per lane.
//
// Ports
//   fab_clk, arst_n            fabric clock, async active-low reset
//   tx_sync_rst                synchronous clear of the TX/OE path only
//   tx_valid, tx_data_in       lane-major TX words, lane c at [c*SER_RATIO +: SER_RATIO]
//   tx_data, oe_data           registered words to the IOD
//   adj_*                      delay-adjust request/ack handshake
//   delay_line_*               IOD delay-line control and status
//   tap_val                    tracked tap value per lane
//   oor_sticky                 only with DDR_CA_OOR_STICKY_EN: latched out-of-range
//
// Build option: define DDR_CA_OOR_STICKY_EN to add per-lane sticky
// out-of-range latches that also block MOVE until the lane is reloaded.
module ddr_ca_lane_ctrl
   import ddr_phy_pkg::*;
#(
   parameter int   NUM_CH      = 2,
   parameter int   SER_RATIO   = 4,
   parameter int   TAP_W       = TAP_W_DEF,
   parameter int   TAP_INIT    = 1,
   parameter int   SETTLE_CYC  = 4,
   parameter int   OE_HOLD_CYC = 2,
   parameter logic IDLE_VAL    = 1'b1,
   localparam int  CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int  LW          = NUM_CH * SER_RATIO
) (
   input  logic                    fab_clk,
   input  logic                    arst_n,
   input  logic                    tx_sync_rst,
   input  logic                    tx_valid,
   input  logic [LW-1:0]           tx_data_in,
   output logic [LW-1:0]           tx_data,
   output logic [LW-1:0]           oe_data,
   input  logic                    adj_req,
   input  logic [CH_W-1:0]         adj_ch,
   input  logic                    adj_load,
   input  logic                    adj_dir,
   input  logic [TAP_W-1:0]        adj_steps,
   output logic                    adj_ack,
   output logic                    adj_err,
   output logic                    adj_busy,
   output logic [NUM_CH-1:0]       delay_line_move,
   output logic [NUM_CH-1:0]       delay_line_direction,
   output logic [NUM_CH-1:0]       delay_line_load,
   input  logic [NUM_CH-1:0]       delay_line_out_of_range,
   output logic [NUM_CH*TAP_W-1:0] tap_val
`ifdef DDR_CA_OOR_STICKY_EN
   ,
   output logic [NUM_CH-1:0]       oor_sticky
`endif
);

   localparam int HOLD_W = (OE_HOLD_CYC > 0) ? $clog2(OE_HOLD_CYC + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LD   = HOLD_W'(OE_HOLD_CYC);
   localparam logic [LW-1:0]     IDLE_WORD = {LW{IDLE_VAL}};

   logic [LW-1:0]     tx_q;
   logic [LW-1:0]     oe_q;
   logic [HOLD_W-1:0] hold_q;
   logic [NUM_CH-1:0] oor_chk;

   // TX/OE path: OE stays on for OE_HOLD_CYC idle cycles after the last
   // valid word (postamble) while the data pins already return to idle.
   always_ff @(posedge fab_clk or negedge arst_n) begin
      if (!arst_n) begin
         tx_q   <= IDLE_WORD;
         oe_q   <= '0;
         hold_q <= '0;
      end else if (tx_sync_rst) begin
         tx_q   <= IDLE_WORD;
         oe_q   <= '0;
         hold_q <= '0;
      end else if (tx_valid) begin
         tx_q   <= tx_data_in;
         oe_q   <= '1;
         hold_q <= HOLD_LD;
      end else begin
         tx_q <= IDLE_WORD;
         if (hold_q != '0) begin
            oe_q   <= '1;
            hold_q <= hold_q - HOLD_W'(1);
         end else begin
            oe_q <= '0;
         end
      end
   end

   assign tx_data = tx_q;
   assign oe_data = oe_q;

`ifdef DDR_CA_OOR_STICKY_EN
   logic [NUM_CH-1:0] sticky_q;

   // Set has priority over the LOAD clear so a lane that is still out of
   // range while being reloaded stays flagged.
   always_ff @(posedge fab_clk or negedge arst_n) begin
      if (!arst_n) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= (sticky_q & ~delay_line_load) | delay_line_out_of_range;
      end
   end

   assign oor_sticky = sticky_q;
   assign oor_chk    = delay_line_out_of_range | sticky_q;
`else
   assign oor_chk    = delay_line_out_of_range;
`endif

   ddr_dl_step_seq #(
      .NUM_CH     (NUM_CH),
      .TAP_W      (TAP_W),
      .TAP_INIT   (TAP_INIT),
      .SETTLE_CYC (SETTLE_CYC),
      .CH_W       (CH_W)
   ) u_step_seq (
      .clk_sys   (fab_clk),
      .rst_b     (arst_n),
      .adj_req   (adj_req),
      .adj_ch    (adj_ch),
      .adj_load  (adj_load),
      .adj_dir   (adj_dir),
      .adj_steps (adj_steps),
      .oor_chk   (oor_chk),
      .adj_ack   (adj_ack),
      .adj_err   (adj_err),
      .adj_busy  (adj_busy),
      .dl_move   (delay_line_move),
      .dl_dir    (delay_line_direction),
      .dl_load   (delay_line_load),
      .tap_val   (tap_val)
   );

endmodule

// File: tb/tb_ddr_ca_lane_ctrl.sv
// Self-checking bench for ddr_ca_lane_ctrl with the default parameters.
module tb_ddr_ca_lane_ctrl;

   localparam int NUM_CH  = 2;
   localparam int TAP_W   = 8;
   localparam int TAP_INI = 1;
   localparam int SETTLE  = 4;
   localparam int HOLD    = 2;
   localparam int TAP_TOP = 255;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        tx_sync_rst;
   logic        tx_valid;
   logic [7:0]  tx_data_in;
   logic [7:0]  tx_data;
   logic [7:0]  oe_data;
   logic        adj_req;
   logic [0:0]  adj_ch;
   logic        adj_load;
   logic        adj_dir;
   logic [7:0]  adj_steps;
   logic        adj_ack;
   logic        adj_err;
   logic        adj_busy;
   logic [1:0]  dl_move;
   logic [1:0]  dl_dir;
   logic [1:0]  dl_load;
   logic [1:0]  dl_oor;
   logic [15:0] tap_val;
`ifdef DDR_CA_OOR_STICKY_EN
   logic [1:0]  oor_sticky;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] exp_tx;
   logic [7:0] exp_oe;
   int         since;
   int         tap_m [NUM_CH];

   always #5 clk = ~clk;

   ddr_ca_lane_ctrl dut (
      .fab_clk                 (clk),
      .arst_n                  (arst_n),
      .tx_sync_rst             (tx_sync_rst),
      .tx_valid                (tx_valid),
      .tx_data_in              (tx_data_in),
      .tx_data                 (tx_data),
      .oe_data                 (oe_data),
      .adj_req                 (adj_req),
      .adj_ch                  (adj_ch),
      .adj_load                (adj_load),
      .adj_dir                 (adj_dir),
      .adj_steps               (adj_steps),
      .adj_ack                 (adj_ack),
      .adj_err                 (adj_err),
      .adj_busy                (adj_busy),
      .delay_line_move         (dl_move),
      .delay_line_direction    (dl_dir),
      .delay_line_load         (dl_load),
      .delay_line_out_of_range (dl_oor),
      .tap_val                 (tap_val)
`ifdef DDR_CA_OOR_STICKY_EN
      ,
      .oor_sticky              (oor_sticky)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // TX reference: output one cycle after the input; OE follows "cycles
   // since the last valid word" against the postamble length.
   task automatic tx_model_reset();
      exp_tx = 8'hFF;
      exp_oe = 8'h00;
      since  = 100;
   endtask

   task automatic tx_step(input logic v, input logic [7:0] d, input logic s);
      @(negedge clk);
      chk("tx_data", tx_data, exp_tx);
      chk("oe_data", oe_data, exp_oe);
      tx_valid    = v;
      tx_data_in  = d;
      tx_sync_rst = s;
      if (s) begin
         tx_model_reset();
      end else if (v) begin
         exp_tx = d;
         exp_oe = 8'hFF;
         since  = 0;
      end else begin
         if (since < 100) since++;
         exp_tx = 8'hFF;
         exp_oe = (since <= HOLD) ? 8'hFF : 8'h00;
      end
   endtask

   // Delay-adjust reference: how many taps fit before a limit.
   task automatic model_req(input int ch, input logic ld, input logic dr, input int steps,
                            input logic blocked, output int n, output int e, output int t);
      int room;
      t = tap_m[ch];
      n = 0;
      e = 0;
      if (ld) begin
         t = TAP_INI;
      end else if (steps != 0) begin
         if (blocked) begin
            e = 1;
         end else begin
            room = dr ? (TAP_TOP - tap_m[ch]) : tap_m[ch];
            n = (steps <= room) ? steps : room;
            e = (steps > room) ? 1 : 0;
            t = dr ? tap_m[ch] + n : tap_m[ch] - n;
         end
      end
   endtask

   task automatic do_adj(input int ch, input logic ld, input logic dr, input int steps,
                         input logic blocked, input string tag);
      int n_exp, e_exp, t_exp;
      int moves, others, loads, last_pulse, got_ack, got_err, bound;
      logic dprev, pulse_prev;
      model_req(ch, ld, dr, steps, blocked, n_exp, e_exp, t_exp);
      @(negedge clk);
      adj_req   = 1'b1;
      adj_ch    = 1'(ch);
      adj_load  = ld;
      adj_dir   = dr;
      adj_steps = 8'(steps);
      moves = 0; others = 0; loads = 0; last_pulse = -1;
      got_ack = 0; got_err = 0;
      dprev = 1'b0; pulse_prev = 1'b0;
      bound = steps * (SETTLE + 2) + 40;
      for (int cyc = 0; cyc < bound && got_ack == 0; cyc++) begin
         @(negedge clk);
         if (pulse_prev) chk({tag, "_dir_after"}, dl_dir[ch], dr);
         if (dl_move[ch]) begin
            moves++;
            chk({tag, "_dir_before"}, dprev, dr);
            chk({tag, "_dir_at"}, dl_dir[ch], dr);
            if (last_pulse >= 0) chk({tag, "_spacing"}, cyc - last_pulse, SETTLE + 1);
            last_pulse = cyc;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (c != ch) others += int'(dl_move[c]) + int'(dl_load[c]);
         end
         if (dl_load[ch]) loads++;
         pulse_prev = dl_move[ch];
         dprev = dl_dir[ch];
         if (adj_ack) begin
            got_ack = 1;
            got_err = int'(adj_err);
            adj_req = 1'b0;
         end
      end
      adj_req = 1'b0;
      chk({tag, "_ack"}, got_ack, 1);
      chk({tag, "_err"}, got_err, e_exp);
      chk({tag, "_moves"}, moves, n_exp);
      chk({tag, "_loads"}, loads, ld ? 1 : 0);
      chk({tag, "_other_lanes"}, others, 0);
      tap_m[ch] = t_exp;
      @(negedge clk);
      chk({tag, "_busy_after"}, adj_busy, 1'b0);
      for (int c = 0; c < NUM_CH; c++) chk({tag, "_tap"}, tap_val[c*TAP_W +: TAP_W], tap_m[c]);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tx"}, tx_data, 8'hFF);
      chk({tag, "_oe"}, oe_data, 8'h00);
      chk({tag, "_move"}, dl_move, 2'b00);
      chk({tag, "_dir"}, dl_dir, 2'b00);
      chk({tag, "_load"}, dl_load, 2'b00);
      chk({tag, "_ack"}, adj_ack, 1'b0);
      chk({tag, "_err"}, adj_err, 1'b0);
      chk({tag, "_busy"}, adj_busy, 1'b0);
      chk({tag, "_taps"}, tap_val, 16'h0101);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      arst_n = 1'b0; tx_sync_rst = 1'b0; tx_valid = 1'b0; tx_data_in = '0;
      adj_req = 1'b0; adj_ch = '0; adj_load = 1'b0; adj_dir = 1'b0; adj_steps = '0;
      dl_oor = 2'b00;
      for (int c = 0; c < NUM_CH; c++) tap_m[c] = TAP_INI;
      tx_model_reset();
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      arst_n = 1'b1;

      // Directed burst: 3 valid words then idle through the postamble.
      for (int i = 0; i < 3; i++) tx_step(1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < 6; i++) tx_step(1'b0, 8'h00, 1'b0);

      // Directed adjusts from the test plan.
      do_adj(1, 1'b0, 1'b1, 3, 1'b0, "up3_ch1");
      do_adj(0, 1'b0, 1'b0, 5, 1'b0, "down5_ch0");
      do_adj(1, 1'b1, 1'b0, 0, 1'b0, "load_ch1");
      do_adj(0, 1'b0, 1'b1, 0, 1'b0, "zero_steps");

      // Random TX traffic running concurrently with random training.
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               tx_step($urandom_range(0, 3) < 2, 8'($urandom), $urandom_range(0, 31) == 0);
            end
            for (int i = 0; i < 4; i++) tx_step(1'b0, 8'h00, 1'b0);
         end
         begin
            for (int i = 0; i < 25; i++) begin
               do_adj($urandom_range(0, 1), $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 6), 1'b0, "rand");
            end
         end
      join

      // Tap range limits.
      do_adj(0, 1'b0, 1'b1, 255, 1'b0, "sat_up");
      do_adj(0, 1'b0, 1'b0, 255, 1'b0, "full_down");

      // Reset during the SETTLE of a 3-step move.
      @(negedge clk);
      adj_req = 1'b1; adj_ch = 1'b1; adj_load = 1'b0; adj_dir = 1'b1; adj_steps = 8'd3;
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         if (dl_move[1]) seen = 1;
      end
      chk("midrst_first_pulse", seen, 1);
      @(negedge clk);
      @(negedge clk);
      arst_n = 1'b0;
      adj_req = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      chk("midrst_no_ack", adj_ack, 1'b0);
      @(negedge clk);
      arst_n = 1'b1;
      for (int c = 0; c < NUM_CH; c++) tap_m[c] = TAP_INI;
      tx_model_reset();
      tx_step(1'b0, 8'h00, 1'b0);
      do_adj(1, 1'b0, 1'b1, 3, 1'b0, "post_rst");
      do_adj(1, 1'b1, 1'b0, 0, 1'b0, "post_rst_load");

      // Out-of-range from the IOD blocks moves.
      @(negedge clk);
      dl_oor = 2'b10;
      do_adj(1, 1'b0, 1'b1, 2, 1'b1, "oor_live");
      dl_oor = 2'b00;
`ifdef DDR_CA_OOR_STICKY_EN
      @(negedge clk);
      chk("sticky_set", oor_sticky, 2'b10);
      do_adj(1, 1'b0, 1'b1, 2, 1'b1, "oor_sticky");
      do_adj(1, 1'b1, 1'b0, 0, 1'b0, "sticky_load");
      chk("sticky_clr", oor_sticky, 2'b00);
`endif
      do_adj(1, 1'b0, 1'b1, 2, 1'b0, "oor_cleared");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
